// File: rtl/ram_backspace.sv
// ram_backspace: cursor tracker for the keyboard-to-VGA text console.
//
// Holds the cursor row, the character count of the current row (num) and
// a per-row length memory. Backspace at column 0 can then step back to the
// end of the previous line. The front end forms the video address as
// row*COLS+num.
//
// Ports:
//   clk   in   processing clock; all state changes on the rising edge
//   rst   in   asynchronous, active-high reset
//   key   in   printable character written this cycle (level, sampled per clock)
//   back  in   Backspace command
//   enter in   Enter command
//   row   out  current cursor row, zero-extended to AW
//   num   out  characters in the current row (cursor column), zero-extended to AW
//   clear out  one-cycle pulse after the screen wraps; video memory must be cleared
//
// Commands are levels with no edge detection. A level held for N cycles
// executes N times. Priority is back > enter > key, and at most one command
// runs per cycle.

module ram_backspace #(
    parameter int COLS = 70,
    parameter int ROWS = 30,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key,
    input  logic          back,
    input  logic          enter,
    output logic [AW-1:0] row,
    output logic [AW-1:0] num,
    output logic          clear
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int NUM_W = $clog2(COLS + 1);

    localparam logic [NUM_W-1:0] COLS_N   = NUM_W'(COLS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_q;
    logic [NUM_W-1:0] num_q;
    logic [NUM_W-1:0] len [ROWS];

    logic [ROW_W-1:0] row_next;
    logic [NUM_W-1:0] num_next;
    logic [ROW_W-1:0] prev_row;
    logic [NUM_W-1:0] len_val;
    logic             adv;
    logic             wrap;

    // Next-state decode. adv marks an "advance row" from enter or a key wrap.
    // wrap marks that same advance taken from the last row.
    always_comb begin
        row_next = row_q;
        num_next = num_q;
        prev_row = row_q - ROW_W'(1);
        len_val  = enter ? num_q : COLS_N;
        adv      = 1'b0;

        if (back) begin
            if (num_q != '0) begin
                num_next = num_q - NUM_W'(1);
            end else if (row_q != '0) begin
                row_next = prev_row;
                num_next = len[prev_row];
            end
        end else if (enter) begin
            adv      = 1'b1;
            num_next = '0;
        end else if (key) begin
            if (num_q == COLS_N) begin
                // The character lands in column 0 of the next row.
                adv      = 1'b1;
                num_next = NUM_W'(1);
            end else begin
                num_next = num_q + NUM_W'(1);
            end
        end

        wrap = adv && (row_q == LAST_ROW);
        if (adv) begin
            row_next = wrap ? '0 : row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            num_q <= '0;
            clear <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                len[i] <= '0;
            end
        end else begin
            row_q <= row_next;
            num_q <= num_next;
            clear <= wrap;
            // A wrap wipes the whole length table. This includes the entry
            // the advancing row would otherwise record.
            if (wrap) begin
                for (int i = 0; i < ROWS; i++) begin
                    len[i] <= '0;
                end
            end else if (adv) begin
                len[row_q] <= len_val;
            end
        end
    end

    assign row = {{(AW - ROW_W){1'b0}}, row_q};
    assign num = {{(AW - NUM_W){1'b0}}, num_q};

endmodule

// File: tb/tb_ram_backspace.sv
// Bench for ram_backspace. It uses a behavioural cursor model, a per-cycle
// compare process, and directed scenarios with literal expectations.

module tb_ram_backspace;

    localparam int COLS = 70;
    localparam int ROWS = 30;
    localparam int AW   = 12;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          key;
    logic          back;
    logic          enter;
    logic [AW-1:0] row;
    logic [AW-1:0] num;
    logic          clear;

    always #5 clk = ~clk;

    ram_backspace #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .back  (back),
        .enter (enter),
        .row   (row),
        .num   (num),
        .clear (clear)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // ---------------- behavioural model ----------------
    // Screen model: cursor position plus the recorded length of each row.
    int m_row = 0;
    int m_num = 0;
    int m_len [ROWS];
    bit m_clear = 1'b0;

    function automatic void m_wipe();
        foreach (m_len[i]) m_len[i] = 0;
    endfunction

    function automatic void m_newline(input int finished_len);
        m_len[m_row] = finished_len;
        if (m_row + 1 < ROWS) begin
            m_row = m_row + 1;
        end else begin
            m_row   = 0;
            m_clear = 1'b1;
            m_wipe();
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_row   = 0;
            m_num   = 0;
            m_clear = 1'b0;
            m_wipe();
        end else begin
            m_clear = 1'b0;
            if (back) begin
                if (m_num > 0) m_num = m_num - 1;
                else if (m_row > 0) begin
                    m_row = m_row - 1;
                    m_num = m_len[m_row];
                end
            end else if (enter) begin
                m_newline(m_num);
                m_num = 0;
            end else if (key) begin
                if (m_num < COLS) m_num = m_num + 1;
                else begin
                    m_newline(COLS);
                    m_num = 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("cyc_row",   32'(row),   32'(m_row));
            check("cyc_num",   32'(num),   32'(m_num));
            check("cyc_clear", 32'(clear), 32'(m_clear));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cmd(input bit b, input bit e, input bit k);
        @(negedge clk);
        back  = b;
        enter = e;
        key   = k;
    endtask

    task automatic idle();
        cmd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmp_en = 1'b0;
        rst    = 1'b1;
        back   = 1'b0;
        enter  = 1'b0;
        key    = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;
    endtask

    // Outputs seen at the negedge right after the last command's posedge.
    task automatic lit(input string name, input int r, input int n);
        check({name, "_row"}, 32'(row), 32'(r));
        check({name, "_num"}, 32'(num), 32'(n));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b0; key = 1'b0; back = 1'b0; enter = 1'b0;
        #2 rst = 1'b1;

        // Reset state and no underflow at the home position.
        do_reset();
        lit("reset", 0, 0);
        check("reset_clear", 32'(clear), 32'd0);
        check("model_reset_row", 32'(m_row), 32'd0);
        cmd(1, 0, 0); idle();
        lit("back_home", 0, 0);

        // Enter records the row length; back at column 0 restores it.
        do_reset();
        repeat (5) cmd(0, 0, 1);
        cmd(0, 1, 0); idle();
        lit("after_enter", 1, 0);
        check("model_len0", 32'(m_len[0]), 32'd5);
        repeat (3) cmd(0, 0, 1);
        idle();
        lit("three_keys", 1, 3);
        repeat (4) cmd(1, 0, 0);
        idle();
        lit("back_to_prev", 0, 5);

        // Full row, then a key wrap onto the next row.
        do_reset();
        repeat (70) cmd(0, 0, 1);
        idle();
        lit("full_row", 0, 70);
        cmd(0, 0, 1); idle();
        lit("key_wrap", 1, 1);
        cmd(1, 0, 0); cmd(1, 0, 0); idle();
        lit("back_wrap", 0, 70);

        // Screen wrap from the last row.
        do_reset();
        repeat (29) cmd(0, 1, 0);
        idle();
        lit("row29", 29, 0);
        check("row29_clear", 32'(clear), 32'd0);
        cmd(0, 1, 0); idle();
        lit("screen_wrap", 0, 0);
        check("wrap_clear_hi", 32'(clear), 32'd1);
        idle();
        check("wrap_clear_lo", 32'(clear), 32'd0);
        cmd(1, 0, 0); idle();
        lit("back_after_wrap", 0, 0);

        // Simultaneous commands follow the priority order.
        do_reset();
        repeat (3) cmd(0, 0, 1);
        cmd(1, 0, 1); idle();
        lit("back_beats_key", 0, 2);
        cmd(0, 1, 1); idle();
        lit("enter_beats_key", 1, 0);

        // Asynchronous reset between clock edges.
        do_reset();
        repeat (7) cmd(0, 1, 0);
        repeat (12) cmd(0, 0, 1);
        idle();
        lit("pre_async", 7, 12);
        @(posedge clk);
        #3;
        cmp_en = 1'b0;
        rst    = 1'b1;
        #1;
        lit("async_rst", 0, 0);
        check("async_clear", 32'(clear), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;
        cmd(1, 0, 0); idle();
        lit("back_after_async", 0, 0);

        // A few random mixed commands checked only by the per-cycle compare.
        repeat (200) cmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 1)));
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
